maze_map: RTL
=============

// Module: maze_map
// PURPOSE
// Maze storage beside the maze solver. Loads a MAZE_SIZE x MAZE_SIZE wall bitmap
// one row per beat. Serves the solver's row/col reads on maze_in and records the
// cells the solver marks with maze_we. Once the solver raises done, streams out
// the coordinates of every marked cell in row-major order.
// PARAMETERS
// MAZE_WIDTH  6  coordinate width; MAZE_SIZE = 2**MAZE_WIDTH (localparam, 64)
// PORTS
// clk         in   1           rising-edge clock
// rst_n       in   1           async active-low reset
// load_valid  in   1           load beat valid
// load_ready  out  1           map accepts a row beat (high only in LOAD)
// load_data   in   MAZE_SIZE   wall bits of current row; bit c = column c, 1 = wall
// solve_en    out  1           high in SOLVE: solver may run
// row, col    in   MAZE_WIDTH  solver cell address
// maze_oe     in   1           solver read strobe
// maze_we     in   1           solver marks cell (row,col) as path
// maze_in     out  1           registered wall bit of last read cell
// done        in   1           solver finished
// path_valid  out  1           path coordinate valid
// path_ready  in   1           downstream accepts coordinate
// path_row    out  MAZE_WIDTH  coordinate row
// path_col    out  MAZE_WIDTH  coordinate col
// dump_done   out  1           high in FINISH (sticky until reset)
// BEHAVIOUR
// - Storage: wall[MAZE_SIZE][MAZE_SIZE], visited[MAZE_SIZE][MAZE_SIZE]. Neither
//   array is reset.
// - Reset: state=LOAD, load_row=0, maze_in=1, path_valid=0, path_row/col=0,
//   solve_en=0, dump_done=0.
// - LOAD: load_ready=1. On load_valid&&load_ready:
//   - wall[load_row] <= load_data; visited[load_row] <= 0; load_row++.
//   - The beat with load_row == MAZE_SIZE-1 moves to SOLVE next cycle.
//   - solver strobes are ignored in LOAD.
// - SOLVE: solve_en=1.
//   - Read: at posedge with maze_oe=1, maze_in <= wall[row][col]. Valid the
//     following cycle (1-cycle latency). maze_in holds when maze_oe=0.
//   - Write: at posedge with maze_we=1, visited[row][col] <= 1. Wall is never
//     modified. A wall cell may still be marked.
//   - oe and we in the same cycle: the read returns the wall bit; the write
//     proceeds. No hazard, because walls are read-only in SOLVE.
//   - done=1: go to DUMP with scan pointer (0,0). A maze_we in that same cycle
//     is still recorded.
// - DUMP: scans one cell per cycle, row-major.
//   - Visited cell: present path_valid=1 with path_row/col. Hold all three
//     stable until path_ready; advance on the handshake.
//   - Unvisited cell: skip in 1 cycle with no output.
//   - Leaving cell (MAZE_SIZE-1,MAZE_SIZE-1), after its handshake if visited,
//     moves to FINISH. An empty map reaches FINISH in MAZE_SIZE^2 cycles.
//   - path_valid must never drop without a handshake.
// - FINISH: dump_done=1. All inputs ignored until rst_n.
// - load_valid outside LOAD: ignored (no back-pressure error).
// - done outside SOLVE: ignored.
// - rst_n low in any state: outputs go to reset values at once. The arrays keep
//   stale contents; LOAD rewrites both per row.
// - Pointers are MAZE_WIDTH wide. Wrap-around is never reached; terminal compare
//   happens first.
// STRUCTURE
// - Shared package maze_pkg: MAZE_WIDTH default; state encodings LOAD=0,
//   SOLVE=1, DUMP=2, FINISH=3; wall/free constants WALL=1, FREE=0.
// - One natural sub-module, maze_path_scanner: DUMP row/col pointer plus the
//   valid/ready output register. Inputs: visited row word, start. Outputs:
//   coordinates and finish pulse.
// - FSM and arrays stay in maze_map.
// TESTING
// - Load 64 rows: row0/row63 all-ones, others 1 at cols 0 and 63, zero inside,
//   with load_valid gapped every 3rd cycle.
//   -> load_ready drops and solve_en=1 one cycle after the 64th beat.
// - SOLVE read (row=5, col=0, oe=1) -> maze_in=1 next cycle. (5,7) -> maze_in=0.
//   No oe -> maze_in holds.
// - Same-cycle oe+we at (3,4) -> maze_in=0; later DUMP emits (3,4).
//   we at wall (0,10) -> emitted; a re-read of (0,10) still returns 1.
// - Mark (1,2),(1,1),(2,1), done=1, path_ready stalled 5 cycles on the first
//   output -> order (1,1),(1,2),(2,1); signals stable during the stall;
//   dump_done after (63,63) scanned.
// - No marks, done=1 -> no path_valid; dump_done exactly 4096 cycles after entry
//   to DUMP.
// - rst_n pulsed mid-DUMP -> path_valid=0 and load_ready=1 immediately.
//   A fresh load clears the previous visited bits (next dump is empty).

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze storage block and its path scanner.
package maze_pkg;

    localparam int DEFAULT_MAZE_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SOLVE  = 2'd1,
        ST_DUMP   = 2'd2,
        ST_FINISH = 2'd3
    } maze_state_e;

    localparam logic WALL = 1'b1;
    localparam logic FREE = 1'b0;

endpackage

// File: rtl/maze_map_if.sv
// Bundle of the load, solver and path-stream signals around maze_map.
interface maze_map_if #(parameter int MAZE_WIDTH = maze_pkg::DEFAULT_MAZE_WIDTH);

    localparam int MAZE_SIZE = 2 ** MAZE_WIDTH;

    logic                  load_valid;
    logic                  load_ready;
    logic [MAZE_SIZE-1:0]  load_data;
    logic                  solve_en;
    logic [MAZE_WIDTH-1:0] row;
    logic [MAZE_WIDTH-1:0] col;
    logic                  maze_oe;
    logic                  maze_we;
    logic                  maze_in;
    logic                  done;
    logic                  path_valid;
    logic                  path_ready;
    logic [MAZE_WIDTH-1:0] path_row;
    logic [MAZE_WIDTH-1:0] path_col;
    logic                  dump_done;

    modport master (
        output load_valid, load_data, row, col, maze_oe, maze_we, done, path_ready,
        input  load_ready, solve_en, maze_in, path_valid, path_row, path_col, dump_done
    );

    modport slave (
        input  load_valid, load_data, row, col, maze_oe, maze_we, done, path_ready,
        output load_ready, solve_en, maze_in, path_valid, path_row, path_col, dump_done
    );

endinterface

// File: rtl/maze_path_scanner.sv
// Row-major scan of the visited map: one cell per cycle, visited cells are
// presented on a valid/ready register and held until accepted.
module maze_path_scanner #(
    parameter int MAZE_WIDTH = maze_pkg::DEFAULT_MAZE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2**MAZE_WIDTH-1:0] visited_word,
    input  logic                     path_ready,
    output logic [MAZE_WIDTH-1:0]    scan_row,
    output logic                     path_valid,
    output logic [MAZE_WIDTH-1:0]    path_row,
    output logic [MAZE_WIDTH-1:0]    path_col,
    output logic                     finish
);

    localparam logic [MAZE_WIDTH-1:0] PTR_ONE = MAZE_WIDTH'(1);

    logic                  active_q, active_d;
    logic                  valid_q, valid_d;
    logic [MAZE_WIDTH-1:0] ptr_row_q, ptr_row_d;
    logic [MAZE_WIDTH-1:0] ptr_col_q, ptr_col_d;
    logic [MAZE_WIDTH-1:0] out_row_q, out_row_d;
    logic [MAZE_WIDTH-1:0] out_col_q, out_col_d;
    logic                  advance_s;

    // Scan step: present a hit, wait for its handshake, or skip an empty cell.
    always_comb begin
        active_d  = active_q;
        valid_d   = valid_q;
        ptr_row_d = ptr_row_q;
        ptr_col_d = ptr_col_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        advance_s = 1'b0;
        finish    = 1'b0;
        if (start) begin
            active_d  = 1'b1;
            valid_d   = 1'b0;
            ptr_row_d = '0;
            ptr_col_d = '0;
        end else if (active_q) begin
            if (valid_q) begin
                if (path_ready) begin
                    valid_d   = 1'b0;
                    advance_s = 1'b1;
                end else begin
                    valid_d   = 1'b1;
                end
            end else if (visited_word[ptr_col_q]) begin
                valid_d   = 1'b1;
                out_row_d = ptr_row_q;
                out_col_d = ptr_col_q;
            end else begin
                advance_s = 1'b1;
            end
            // The last cell ends the scan before the pointer could wrap.
            if (advance_s) begin
                if ((&ptr_row_q) && (&ptr_col_q)) begin
                    finish   = 1'b1;
                    active_d = 1'b0;
                end else if (&ptr_col_q) begin
                    ptr_col_d = '0;
                    ptr_row_d = ptr_row_q + PTR_ONE;
                end else begin
                    ptr_col_d = ptr_col_q + PTR_ONE;
                end
            end else begin
                finish = 1'b0;
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Scanner state and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            valid_q   <= 1'b0;
            ptr_row_q <= '0;
            ptr_col_q <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            active_q  <= active_d;
            valid_q   <= valid_d;
            ptr_row_q <= ptr_row_d;
            ptr_col_q <= ptr_col_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    assign scan_row   = ptr_row_q;
    assign path_valid = valid_q;
    assign path_row   = out_row_q;
    assign path_col   = out_col_q;

endmodule

// File: rtl/maze_map.sv
// Maze wall/visited storage: row-wise load, solver read/mark port, and a
// row-major dump of the marked cells once the solver is done.
module maze_map
    import maze_pkg::*;
#(
    parameter int MAZE_WIDTH = DEFAULT_MAZE_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    maze_map_if.slave  bus
);

    localparam int                    MAZE_SIZE = 2 ** MAZE_WIDTH;
    localparam logic [MAZE_WIDTH-1:0] ROW_ONE   = MAZE_WIDTH'(1);
    localparam logic [MAZE_WIDTH-1:0] LAST_ROW  = '1;

    logic [MAZE_SIZE-1:0] wall_mem    [MAZE_SIZE];
    logic [MAZE_SIZE-1:0] visited_mem [MAZE_SIZE];

    maze_state_e           state_q, state_d;
    logic [MAZE_WIDTH-1:0] load_row_q, load_row_d;
    logic                  maze_in_q, maze_in_d;

    logic                  load_fire_s;
    logic                  start_s;
    logic                  scan_finish_s;
    logic [MAZE_WIDTH-1:0] scan_row_s;

    assign load_fire_s = (state_q == ST_LOAD) && bus.load_valid;
    assign start_s     = (state_q == ST_SOLVE) && bus.done;

    maze_path_scanner #(.MAZE_WIDTH(MAZE_WIDTH)) u_scanner (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_s),
        .visited_word (visited_mem[scan_row_s]),
        .path_ready   (bus.path_ready),
        .scan_row     (scan_row_s),
        .path_valid   (bus.path_valid),
        .path_row     (bus.path_row),
        .path_col     (bus.path_col),
        .finish       (scan_finish_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (load_fire_s && (load_row_q == LAST_ROW)) state_d = ST_SOLVE;
                else                                         state_d = ST_LOAD;
            end
            ST_SOLVE: begin
                if (bus.done) state_d = ST_DUMP;
                else          state_d = ST_SOLVE;
            end
            ST_DUMP: begin
                if (scan_finish_s) state_d = ST_FINISH;
                else               state_d = ST_DUMP;
            end
            ST_FINISH: state_d = ST_FINISH;
            default:   state_d = ST_LOAD;
        endcase
    end

    // FSM outputs, decoded from the state register only.
    always_comb begin
        bus.load_ready = (state_q == ST_LOAD);
        bus.solve_en   = (state_q == ST_SOLVE);
        bus.dump_done  = (state_q == ST_FINISH);
    end

    // Load row pointer and the registered read-back bit.
    always_comb begin
        load_row_d = load_row_q;
        maze_in_d  = maze_in_q;
        if (load_fire_s) begin
            load_row_d = load_row_q + ROW_ONE;
        end else begin
            load_row_d = load_row_q;
        end
        if ((state_q == ST_SOLVE) && bus.maze_oe) begin
            maze_in_d = wall_mem[bus.row][bus.col];
        end else begin
            maze_in_d = maze_in_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_row_q <= '0;
            maze_in_q  <= WALL;
        end else begin
            load_row_q <= load_row_d;
            maze_in_q  <= maze_in_d;
        end
    end

    // Map storage is not reset; each load beat rewrites a whole row of both arrays.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            wall_mem[load_row_q]    <= bus.load_data;
            visited_mem[load_row_q] <= {MAZE_SIZE{FREE}};
        end else if ((state_q == ST_SOLVE) && bus.maze_we) begin
            visited_mem[bus.row][bus.col] <= 1'b1;
        end else begin
            visited_mem[bus.row][bus.col] <= visited_mem[bus.row][bus.col];
        end
    end

    assign bus.maze_in = maze_in_q;

endmodule
